// File: rtl/trig_pulse_pkg.sv
// Shared types and defaults for the trigger pulse generator.
//   state_e        : FSM encoding (idle, delay countdown, gate high)
//   CNT_W_DEFAULT  : default width of the delay/width configuration and down-counter
package trig_pulse_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDelay = 2'd1,
    StHigh  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_down_cnt.sv
// Loadable down-counter with zero flag. Decrement saturates at zero so the count never wraps.
// Ports:
//   i_clk      : clock, posedge
//   i_rst_n    : asynchronous active-low reset, clears the count
//   i_load     : load i_load_val (has priority over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement by one when non-zero
//   o_cnt      : current count
//   o_zero     : count equals zero
module pulse_down_cnt
  import trig_pulse_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_load) begin
      w_cnt_d = i_load_val;
    end else if (i_dec && !w_zero) begin
      w_cnt_d = r_cnt - CntOne;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = w_zero;

endmodule

// File: rtl/trig_pulse_gen.sv
// Trigger-to-gate pulse generator: after a trigger, waits delay_cfg cycles then drives
// o_pulse_out high for width_cfg cycles, strobes o_done on completion and o_missed for
// triggers ignored while busy. All outputs are registered.
// Build option: TRIG_PULSE_RETRIG_EN -- when defined, a trigger while busy restarts the
// sequence with freshly latched configuration instead of being reported as missed.
// Ports:
//   i_clk       : clock, posedge
//   i_rst_n     : asynchronous active-low reset
//   i_trigger   : one-cycle start strobe
//   i_delay_cfg : cycles from trigger acceptance to first high cycle
//   i_width_cfg : number of high cycles
//   o_pulse_out : gate output
//   o_busy      : sequence in progress (delay or high)
//   o_done      : one-cycle completion strobe
//   o_missed    : one-cycle strobe for a trigger that was not accepted
module trig_pulse_gen
  import trig_pulse_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_trigger,
  input  logic [CNT_W-1:0] i_delay_cfg,
  input  logic [CNT_W-1:0] i_width_cfg,
  output logic             o_pulse_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_missed
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  state_e           w_state_d;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] w_width_d;
  logic             r_pulse;
  logic             r_busy;
  logic             r_done;
  logic             r_missed;
  logic             w_done_d;
  logic             w_missed_d;
  logic             w_accept;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic [CNT_W-1:0] w_cnt;
  logic             w_zero;

`ifdef TRIG_PULSE_RETRIG_EN
  // Any trigger restarts the sequence, whatever state we are in.
  assign w_accept   = i_trigger;
  assign w_missed_d = 1'b0;
`else
  assign w_accept   = i_trigger && (r_state == StIdle);
  assign w_missed_d = i_trigger && (r_state != StIdle);
`endif

  pulse_down_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_state_d  = r_state;
    w_width_d  = r_width;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    w_done_d   = 1'b0;
    if (w_accept) begin
      // Width is held for the delay->high transition; delay is consumed right here.
      w_width_d = i_width_cfg;
      if (i_delay_cfg != '0) begin
        w_state_d  = StDelay;
        w_load     = 1'b1;
        w_load_val = i_delay_cfg - CntOne;
      end else if (i_width_cfg != '0) begin
        w_state_d  = StHigh;
        w_load     = 1'b1;
        w_load_val = i_width_cfg - CntOne;
      end else begin
        w_state_d = StIdle;
        w_done_d  = 1'b1;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_d = StIdle;
        end
        StDelay: begin
          if (w_zero) begin
            if (r_width != '0) begin
              w_state_d  = StHigh;
              w_load     = 1'b1;
              w_load_val = r_width - CntOne;
            end else begin
              w_state_d = StIdle;
              w_done_d  = 1'b1;
            end
          end else begin
            w_dec = 1'b1;
          end
        end
        StHigh: begin
          if (w_zero) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_width  <= '0;
      r_pulse  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_width  <= w_width_d;
      r_pulse  <= (w_state_d == StHigh);
      r_busy   <= (w_state_d != StIdle);
      r_done   <= w_done_d;
      r_missed <= w_missed_d;
    end
  end

  assign o_pulse_out = r_pulse;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_missed    = r_missed;

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Self-checking bench for trig_pulse_gen: per-cycle vector table plus reset sequences.
module tb_trig_pulse_gen;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic [15:0] dcfg;
  logic [15:0] wcfg;
  logic        pulse;
  logic        busy;
  logic        done;
  logic        missed;

  int total = 0;
  int bad   = 0;

  trig_pulse_gen #(
    .CNT_W (16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_trigger   (trig),
    .i_delay_cfg (dcfg),
    .i_width_cfg (wcfg),
    .o_pulse_out (pulse),
    .o_busy      (busy),
    .o_done      (done),
    .o_missed    (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output encodings {pulse, busy, done, missed}
  localparam logic [3:0] E0   = 4'b0000;
  localparam logic [3:0] EB   = 4'b0100;
  localparam logic [3:0] EPB  = 4'b1100;
  localparam logic [3:0] ED   = 4'b0010;
  localparam logic [3:0] EPBM = 4'b1101;

  typedef struct {
    logic        trig;
    logic [15:0] d;
    logic [15:0] w;
    logic [3:0]  exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic t, input int d, input int w, input logic [3:0] e);
    vec_t v;
    v.trig = t;
    v.d    = d[15:0];
    v.w    = w[15:0];
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {pulse, busy, done, missed};
  endfunction

  int hi;
  int done_k;

  initial begin
    rst_n = 1'b0;
    trig  = 1'b0;
    dcfg  = 16'd0;
    wcfg  = 16'd1;

    // Held in reset: triggers must have no effect.
    for (int i = 0; i < 4; i++) begin
      trig = i[0];
      tick();
      check($sformatf("in_reset[%0d]", i), int'(outs()), int'(E0));
    end
    trig = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_reset[%0d]", i), int'(outs()), int'(E0));
    end

    // D=3 W=5; cfg changes after acceptance must be ignored.
    add(1, 3, 5, EB);
    add(0, 7, 9, EB);
    add(0, 7, 9, EB);
    for (int k = 4; k <= 8; k++) add(0, 0, 0, EPB);
    add(0, 0, 0, ED);
    add(0, 0, 0, E0);
    // D=0 W=1
    add(1, 0, 1, EPB);
    add(0, 0, 1, ED);
    add(0, 0, 1, E0);
    // D=0 W=0
    add(1, 0, 0, ED);
    add(0, 0, 0, E0);
    // D=1 W=0
    add(1, 1, 0, EB);
    add(0, 1, 0, ED);
    add(0, 1, 0, E0);
    // D=1 W=2 with back-to-back trigger in the done cycle
    add(1, 1, 2, EB);
    add(0, 1, 2, EPB);
    add(0, 1, 2, EPB);
    add(0, 1, 2, ED);
    add(1, 1, 2, EB);
    add(0, 1, 2, EPB);
    add(0, 1, 2, EPB);
    add(0, 1, 2, ED);
    add(0, 1, 2, E0);
    // D=2 W=4 with second trigger three cycles later
    add(1, 2, 4, EB);
    add(0, 2, 4, EB);
    add(0, 2, 4, EPB);
`ifdef TRIG_PULSE_RETRIG_EN
    add(1, 2, 4, EB);
    add(0, 2, 4, EB);
    for (int k = 6; k <= 9; k++) add(0, 2, 4, EPB);
    add(0, 2, 4, ED);
    add(0, 2, 4, E0);
`else
    add(1, 2, 4, EPBM);
    add(0, 2, 4, EPB);
    add(0, 2, 4, EPB);
    add(0, 2, 4, ED);
    add(0, 2, 4, E0);
`endif

    foreach (vecs[i]) begin
      trig = vecs[i].trig;
      dcfg = vecs[i].d;
      wcfg = vecs[i].w;
      tick();
      check($sformatf("vec[%0d]", i), int'(outs()), int'(vecs[i].exp));
    end
    trig = 1'b0;

    // Mid-pulse reset with D=0 W=100.
    dcfg = 16'd0;
    wcfg = 16'd100;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("long_first_high", int'(outs()), int'(EPB));
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_drop", int'(outs()), int'(E0));
    tick();
    tick();
    check("held_reset", int'(outs()), int'(E0));
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("no_done_after_abort[%0d]", i), int'(outs()), int'(E0));
    end

    // Fresh full-length pulse after reset, bounded wait.
    hi     = 0;
    done_k = 0;
    trig   = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (k == 1) trig = 1'b0;
      if (pulse) hi++;
      if (done && done_k == 0) done_k = k;
    end
    check("long_high_cycles", hi, 100);
    check("long_done_edge", done_k, 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
